// File: rtl/iq_sample_packer.sv
// ---------------------------------------------------------------------------
// iq_sample_packer
//
// Requantises complex IQ samples from 16-bit components to BITS bits each
// and packs SPW = OUT_WIDTH/(2*BITS) samples per output word. The first
// sample of a word lands in the most significant lane. i_tlast flushes a
// partial word with zero padding.
//
// Requantisation modes:
//   ROUND = 0 : plain truncation.
//   ROUND = 1 : round half-up with saturation at the maximum positive value.
//
// Ports:
//   clk       in   clock, all logic on the rising edge
//   reset     in   synchronous, active-high reset
//   i_tdata   in   {I[15:0], Q[15:0]}, two's complement
//   i_tlast   in   last sample of the input packet
//   i_tvalid  in   input valid
//   i_tready  out  input ready
//   o_tdata   out  packed output word
//   o_tlast   out  last word of the packet
//   o_tvalid  out  output valid
//   o_tready  in   output ready
//   o_pad     out  number of zero-padded sample lanes in o_tdata
// ---------------------------------------------------------------------------
module iq_sample_packer #(
    parameter int BITS      = 4,
    parameter int OUT_WIDTH = 32,
    parameter int ROUND     = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [31:0]                              i_tdata,
    input  logic                                     i_tlast,
    input  logic                                     i_tvalid,
    output logic                                     i_tready,
    output logic [OUT_WIDTH-1:0]                     o_tdata,
    output logic                                     o_tlast,
    output logic                                     o_tvalid,
    input  logic                                     o_tready,
    output logic [$clog2(OUT_WIDTH/(2*BITS)+1)-1:0]  o_pad
);

    localparam int SW    = 2 * BITS;
    localparam int SPW   = OUT_WIDTH / SW;
    localparam int PADW  = $clog2(SPW + 1);
    localparam int LANEW = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [LANEW-1:0] LAST_LANE = LANEW'(SPW - 1);

    // Bit just below the kept field; only meaningful when BITS < 16.
    localparam int RBIT = (BITS < 16) ? (15 - BITS) : 0;

    // Largest positive BITS-wide two's complement value (0 then all ones).
    localparam logic [BITS-1:0] MAXPOS = BITS'((32'd1 << (BITS - 1)) - 32'd1);

    // Refuse to elaborate a configuration where samples do not tile the word.
    generate
        if ((BITS < 1) || (BITS > 16) || ((OUT_WIDTH % (2 * BITS)) != 0)) begin : g_bad_cfg
            $error("iq_sample_packer: BITS must be 1..16 and OUT_WIDTH a multiple of 2*BITS");
        end
    endgenerate

    // Keep the top BITS bits; optionally add the next bit down as a rounding
    // increment, except at the positive maximum where adding would wrap.
    // Negative values can never wrap because the increment moves them
    // toward zero.
    function automatic logic [BITS-1:0] requant(input logic [15:0] c);
        logic [BITS-1:0] t;
        t = c[15 -: BITS];
        if ((ROUND != 0) && (BITS < 16) && c[RBIT] && (t != MAXPOS))
            t = t + BITS'(1);
        return t;
    endfunction

    logic [LANEW-1:0]     r_lane;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_tdata;
    logic                 r_tlast;
    logic                 r_tvalid;
    logic [PADW-1:0]      r_pad;

    logic [SW-1:0]        w_sample;
    logic [OUT_WIDTH-1:0] w_merged;
    logic                 w_completing;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_unused;

    // Bits of i_tdata below the rounding position never influence the result.
    assign w_unused = &{1'b0, i_tdata};

    // Build the requantised sample and drop it into the current lane of the
    // accumulator. Unfilled lanes of r_acc are always zero, so OR-ing is
    // enough and the lanes below the current one stay zero on a flush.
    always_comb begin
        w_sample = {requant(i_tdata[31:16]), requant(i_tdata[15:0])};
        w_merged = r_acc | (OUT_WIDTH'(w_sample) << (SW * (SPW - 1 - int'(r_lane))));
    end

    // A beat that would load the output register can only go when that
    // register is free or being drained this cycle. Beats that merely fill
    // the accumulator are never stalled. i_tvalid is deliberately absent.
    assign w_completing = (r_lane == LAST_LANE) || i_tlast;
    assign w_ready      = !w_completing || !r_tvalid || o_tready;
    assign w_accept     = i_tvalid && w_ready;

    // Lane counter, accumulator and output holding register. A completing
    // beat accepted in the same cycle the held word drains simply reloads
    // the register, keeping o_tvalid high for full throughput. Reset throws
    // away both the partial accumulation and any word still held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane   <= '0;
            r_acc    <= '0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_pad    <= '0;
        end else begin
            if (r_tvalid && o_tready)
                r_tvalid <= 1'b0;

            if (w_accept) begin
                if (w_completing) begin
                    r_tdata  <= w_merged;
                    r_tlast  <= i_tlast;
                    r_pad    <= PADW'(SPW - 1 - int'(r_lane));
                    r_tvalid <= 1'b1;
                    r_acc    <= '0;
                    r_lane   <= '0;
                end else begin
                    r_acc    <= w_merged;
                    r_lane   <= r_lane + LANEW'(1);
                end
            end
        end
    end

    assign i_tready = w_ready;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign o_tvalid = r_tvalid;
    assign o_pad    = r_pad;

endmodule
